rep3_serial_tx: RTL and testbench

REP3_SERIAL_TX -- requirements
Module: rep3_serial_tx

---
 rtl/rep3_serial_tx.sv | 125 ++++++++++++
 tb/tb_rep3_serial_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rep3_serial_tx.sv
// Repetition-3 serial transmitter: start/data/stop bits each sent as three identical
// symbols of CLKS_PER_SYM cycles, for a majority-vote receiver. Optional single-symbol fault injection.
module rep3_serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_SYM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              err_inj,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    BitW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]     SymLast = 8'(CLKS_PER_SYM - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        clk_cnt_q, clk_cnt_d;
  logic [1:0]        rep_q, rep_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              sym_end, rep_end;

  assign sym_end = (clk_cnt_q == SymLast);
  assign rep_end = sym_end && (rep_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    rep_d     = rep_q;
    bit_d     = bit_q;
    data_d    = data_q;
    err_d     = err_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    // Symbol timing and copy counting are shared by all busy states.
    if (state_q != StIdle) begin
      if (sym_end) begin
        clk_cnt_d = '0;
        rep_d     = rep_end ? 2'd0 : rep_q + 2'd1;
      end else begin
        clk_cnt_d = clk_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StStart;
          data_d    = in_data;
          err_d     = err_inj;
          clk_cnt_d = '0;
          rep_d     = 2'd0;
          bit_d     = '0;
        end
      end
      StStart: begin
        if (rep_end) state_d = StData;
      end
      StData: begin
        if (rep_end) begin
          if (bit_q == BitLast) begin
            state_d = StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StStop: begin
        if (rep_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is computed from next-state values so tx_out comes straight from a flop.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = data_d[bit_d] ^ (err_d && (bit_d == '0) && (rep_d == 2'd1));
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      rep_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      rep_q     <= rep_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign tx_out   = tx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Bench for rep3_serial_tx: literal frame table, reference-model random frames,
// back-to-back, mid-frame reset and a CLKS_PER_SYM=1 instance.
module tb_rep3_serial_tx;

  localparam int DW    = 8;
  localparam int CPS   = 4;
  localparam int NSYM  = 3 * (DW + 2);
  localparam int FLEN  = NSYM * CPS;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, err_inj, tx_out, busy, done;
  logic [DW-1:0] in_data;
  logic in_valid1, in_ready1, err_inj1, tx_out1, busy1, done1;
  logic [DW-1:0] in_data1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rep3_serial_tx #(.DATA_W(DW), .CLKS_PER_SYM(CPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .err_inj(err_inj), .tx_out(tx_out), .busy(busy), .done(done)
  );

  rep3_serial_tx #(.DATA_W(DW), .CLKS_PER_SYM(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .err_inj(err_inj1), .tx_out(tx_out1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic            err;
    logic [NSYM-1:0] pat;  // leftmost = first symbol on the line
  } vec_t;

  task automatic check(input string nm, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Frame built from the logical bit sequence: start, LSB-first data, stop, each tripled.
  function automatic logic [NSYM-1:0] model_pat(input logic [DW-1:0] d, input logic e);
    logic lbits[DW+2];
    logic [NSYM-1:0] p;
    lbits[0] = 1'b0;
    for (int b = 0; b < DW; b++) lbits[b+1] = d[b];
    lbits[DW+1] = 1'b1;
    for (int s = 0; s < NSYM; s++) begin
      p[NSYM-1-s] = lbits[s/3] ^ (e && s == 4);
    end
    return p;
  endfunction

  task automatic start_frame(input logic [DW-1:0] d, input logic e);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", w, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    err_inj  = e;
  endtask

  // Checks cycles 1..FLEN after accept plus the done cycle; decodes with a majority vote.
  task automatic check_frame(input logic [NSYM-1:0] pat, input logic [DW-1:0] d,
                             input logic hold, input logic [DW-1:0] nxt,
                             input logic scramble);
    logic cap[FLEN];
    logic [DW-1:0] dec;
    int votes;
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = hold;
        in_data  = nxt;
        err_inj  = ~err_inj;
      end else if (scramble) begin
        in_data = DW'($urandom);
        err_inj = 1'($urandom);
      end
      cap[i] = tx_out;
      check("tx_out", i + 1, {31'd0, tx_out}, {31'd0, pat[NSYM-1-i/CPS]});
      check("busy", i + 1, {31'd0, busy}, 32'd1);
      if (i % 8 == 0) begin
        check("in_ready_busy", i + 1, {31'd0, in_ready}, 32'd0);
        check("done_busy", i + 1, {31'd0, done}, 32'd0);
      end
    end
    @(negedge clk);
    check("done_pulse", FLEN + 1, {31'd0, done}, 32'd1);
    check("idle_tx", FLEN + 1, {31'd0, tx_out}, 32'd1);
    check("idle_busy", FLEN + 1, {31'd0, busy}, 32'd0);
    check("idle_ready", FLEN + 1, {31'd0, in_ready}, 32'd1);
    for (int b = 0; b < DW; b++) begin
      votes = 0;
      for (int k = 0; k < 3; k++) votes += int'(cap[(3 * (b + 1) + k) * CPS + CPS / 2]);
      dec[b] = (votes >= 2);
    end
    check("majority_decode", 0, {24'd0, dec}, {24'd0, d});
    if (!hold) begin
      @(negedge clk);
      check("done_once", FLEN + 2, {31'd0, done}, 32'd0);
      check("idle_tx2", FLEN + 2, {31'd0, tx_out}, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[5];
    logic [DW-1:0] rd;
    logic re;
    logic [NSYM-1:0] p80;

    vt[0] = '{8'hA5, 1'b0, 30'b000_111_000_111_000_000_111_000_111_111};
    vt[1] = '{8'h01, 1'b0, 30'b000_111_000_000_000_000_000_000_000_111};
    vt[2] = '{8'h01, 1'b1, 30'b000_101_000_000_000_000_000_000_000_111};
    vt[3] = '{8'h3C, 1'b0, 30'b000_000_000_111_111_111_111_000_000_111};
    vt[4] = '{8'h00, 1'b1, 30'b000_010_000_000_000_000_000_000_000_111};
    p80   = 30'b000_000_000_000_000_000_000_000_111_111;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; err_inj = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; err_inj1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 0, {31'd0, tx_out}, 32'd1);
    check("rst_busy", 0, {31'd0, busy}, 32'd0);
    check("rst_done", 0, {31'd0, done}, 32'd0);
    check("rst_ready", 0, {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // CLKS_PER_SYM=1 instance: 30-cycle frame, MSB copies last before stop.
    @(negedge clk);
    in_valid1 = 1'b1;
    in_data1  = 8'h80;
    for (int i = 0; i < NSYM; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
      end
      check("c1_tx", i + 1, {31'd0, tx_out1}, {31'd0, p80[NSYM-1-i]});
      check("c1_busy", i + 1, {31'd0, busy1}, 32'd1);
    end
    @(negedge clk);
    check("c1_done", NSYM + 1, {31'd0, done1}, 32'd1);
    check("c1_busy_end", NSYM + 1, {31'd0, busy1}, 32'd0);

    // Literal frame table; inputs scrambled during the frame.
    for (int v = 0; v < 5; v++) begin
      start_frame(vt[v].data, vt[v].err);
      check_frame(vt[v].pat, vt[v].data, 1'b0, 8'h00, 1'b1);
    end

    // Back-to-back with in_valid held: 0x00 then 0xFF accepted in the done cycle.
    start_frame(8'h00, 1'b0);
    check_frame(model_pat(8'h00, 1'b0), 8'h00, 1'b1, 8'hFF, 1'b0);
    err_inj = 1'b0;
    check_frame(model_pat(8'hFF, 1'b0), 8'hFF, 1'b0, 8'h00, 1'b0);

    // Randomized frames against the reference model.
    for (int r = 0; r < 6; r++) begin
      rd = DW'($urandom);
      re = ($urandom_range(0, 3) == 0);
      start_frame(rd, re);
      check_frame(model_pat(rd, re), rd, 1'b0, DW'($urandom), 1'b1);
    end

    // Mid-frame reset with a simultaneous in_valid, then a frame right after release.
    start_frame(8'h55, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("pre_rst_busy", 50, {31'd0, busy}, 32'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    err_inj = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", 0, {31'd0, tx_out}, 32'd1);
    check("mid_rst_busy", 0, {31'd0, busy}, 32'd0);
    check("mid_rst_done", 0, {31'd0, done}, 32'd0);
    check("mid_rst_ready", 0, {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    check_frame(vt[3].pat, 8'h3C, 1'b0, 8'hC3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
